// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Streams a program from a host into instruction memory, verifies a 16-bit
//   additive checksum sent after the last word, then enables the CPU.
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   synchronous active-high reset
//   start       in   1   load request (honoured in IDLE, RUN, ERROR)
//   word_count  in   8   program length in words, 0 encodes 256
//   in_data     in  16   host program / checksum word
//   in_valid    in   1   host word valid
//   in_ready    out  1   loader accepts a word this cycle
//   imem_we     out  1   instruction-memory write strobe
//   imem_addr   out  8   instruction-memory write address (0 when idle)
//   imem_data   out 16   instruction-memory write data (0 when idle)
//   cpu_enable  out  1   CPU enable, high only in RUN
//   busy        out  1   high while loading or checking
//   error       out  1   high after a checksum mismatch
//
// The write port is combinational from the accepted transfer so that a word
// reaches memory in the same cycle it is handed over, at one word per clock.
// ---------------------------------------------------------------------------
module prog_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  word_count,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [15:0] imem_data,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error
);

  localparam int unsigned AddrW = 8;
  localparam int unsigned CntW  = 9;
  localparam int unsigned DataW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_e;

  state_e             state_q, state_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [CntW-1:0]    remaining_q, remaining_d;
  logic [DataW-1:0]   sum_q, sum_d;

  logic               xfer;
  logic [CntW-1:0]    load_len;

  // Length of the requested program; a zero count means a full 256 words.
  assign load_len = (word_count == '0) ? CntW'(256) : CntW'(word_count);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      sum_q       <= sum_d;
    end
  end

  // Handshake: ready only while a load or checksum word is expected, and
  // forced low during reset so a held in_valid never transfers.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
    end
  end

  assign xfer = in_valid && in_ready;

  // Status outputs, decoded from state and held low during reset.
  always_comb begin
    cpu_enable = 1'b0;
    busy       = 1'b0;
    error      = 1'b0;
    if (!reset) begin
      cpu_enable = (state_q == S_RUN);
      busy       = (state_q == S_LOAD) || (state_q == S_CHECK);
      error      = (state_q == S_ERROR);
    end
  end

  // Next-state, datapath update and memory write port.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    sum_d       = sum_q;
    imem_we     = 1'b0;
    imem_addr   = '0;
    imem_data   = '0;

    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          state_d     = S_LOAD;
          addr_d      = '0;
          remaining_d = load_len;
          sum_d       = '0;
        end
      end

      S_LOAD: begin
        if (xfer) begin
          imem_we     = 1'b1;
          imem_addr   = addr_q;
          imem_data   = in_data;
          // Address wraps naturally after word 255; nothing else depends on it.
          addr_d      = addr_q + AddrW'(1);
          sum_d       = sum_q + in_data;
          remaining_d = remaining_q - CntW'(1);
          if (remaining_q == CntW'(1)) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        // Checksum word is compared only, never written to memory.
        if (xfer) begin
          state_d = (in_data == sum_q) ? S_RUN : S_ERROR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  word_count;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        cpu_enable;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  int writes_exp = 0;
  bit done = 0;

  // Expected memory writes: {addr, data}
  logic [23:0] exp_q[$];
  logic [7:0]  exp_addr;

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .error      (error)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Monitor: pops expected writes when the DUT writes; checks idle bus is 0.
  always @(negedge clk) begin
    if (!done) begin
      if (imem_we) begin
        writes_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", imem_addr, imem_data);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          if ({imem_addr, imem_data} !== e) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                     imem_addr, imem_data, e[23:16], e[15:0]);
          end
        end
      end else begin
        checks++;
        if (imem_addr !== 8'd0 || imem_data !== 16'd0) begin
          errors++;
          $display("FAIL idle_bus: got addr=%0d data=%h, expected 0/0", imem_addr, imem_data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Checks {in_ready, cpu_enable, busy, error}
  task automatic chk_status(input string name, input logic [3:0] exp);
    chk(name, 32'({in_ready, cpu_enable, busy, error}), 32'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] wc);
    start = 1;
    word_count = wc;
    step();
    start = 0;
    word_count = 8'hA5;
    exp_addr = 8'd0;
  endtask

  // One transfer; leaves in_valid high so calls can run back-to-back.
  task automatic xfer(input logic [15:0] d, input bit is_prog);
    int n;
    in_valid = 1;
    in_data = d;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready=0, expected 1");
    end else if (is_prog) begin
      exp_q.push_back({exp_addr, d});
      exp_addr = exp_addr + 8'd1;
      writes_exp++;
    end
    step();
  endtask

  task automatic idle_bus();
    in_valid = 0;
    in_data = 16'h0;
  endtask

  initial begin
    reset = 1;
    start = 0;
    word_count = 0;
    in_data = 0;
    in_valid = 0;
    exp_addr = 0;
    #1;
    chk_status("reset_status_during", 4'b0000);
    step();
    step();
    chk_status("reset_status_after_edge", 4'b0000);
    reset = 0;
    step();
    chk_status("idle_status", 4'b0000);

    // Basic load, back-to-back.
    do_start(8'd3);
    chk_status("load_status", 4'b1010);
    xfer(16'h1111, 1);
    xfer(16'h2222, 1);
    xfer(16'h0003, 1);
    chk_status("check_status", 4'b1010);
    xfer(16'h3336, 0);
    idle_bus();
    chk_status("basic_run", 4'b0100);

    // Bad checksum from RUN.
    do_start(8'd3);
    chk_status("restart_from_run", 4'b1010);
    xfer(16'h1111, 1);
    xfer(16'h2222, 1);
    xfer(16'h0003, 1);
    xfer(16'h3337, 0);
    idle_bus();
    chk_status("bad_checksum_error", 4'b0001);
    step();
    chk_status("error_holds", 4'b0001);

    // Recover from ERROR with a single-word program.
    do_start(8'd1);
    xfer(16'hFFFF, 1);
    xfer(16'hFFFF, 0);
    idle_bus();
    chk_status("one_word_run", 4'b0100);

    // Sum wraps modulo 2^16.
    do_start(8'd2);
    xfer(16'hFFFF, 1);
    xfer(16'h0002, 1);
    xfer(16'h0001, 0);
    idle_bus();
    chk_status("sum_wrap_run", 4'b0100);

    // Full 256-word program; sum of 0..255 = 0x7F80.
    do_start(8'd0);
    for (int i = 0; i < 256; i++) begin
      xfer(16'(i), 1);
    end
    chk_status("full_in_check", 4'b1010);
    xfer(16'h7F80, 0);
    idle_bus();
    chk_status("full_run", 4'b0100);

    // Throttled load with start pulses inserted mid-LOAD.
    do_start(8'd3);
    for (int k = 0; k < 3; k++) begin
      idle_bus();
      start = 1;
      word_count = 8'd7;
      step();
      start = (k == 1);
      xfer(16'h0100 + 16'(k), 1);
      start = 0;
    end
    idle_bus();
    step();
    chk_status("throttle_in_check", 4'b1010);
    xfer(16'h0303, 0);
    idle_bus();
    chk_status("throttle_run", 4'b0100);

    // Reset after 2 of 4 words, with in_valid held high.
    do_start(8'd4);
    xfer(16'hAAAA, 1);
    xfer(16'h5555, 1);
    reset = 1;
    #1;
    chk_status("mid_load_reset_during", 4'b0000);
    step();
    reset = 0;
    #1;
    chk_status("mid_load_reset_after", 4'b0000);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_status("post_reset_idle", 4'b0000);
    end
    idle_bus();

    // Fresh load after abandoned one.
    do_start(8'd1);
    xfer(16'h0005, 1);
    xfer(16'h0005, 0);
    idle_bus();
    chk_status("post_reset_run", 4'b0100);

    step();
    step();
    done = 1;
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    chk("write_count", 32'(writes_seen), 32'(writes_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
